mips_cpu_harvard_core: RTL and testbench

- Single-cycle, 32-bit MIPS-I subset CPU with separate instruction and data memory ports (Harvard).
- Memories are external and combinational-read; this block holds the PC, the 32x32 register file, decode, ALU and branch logic.
- Top-level processor block of the CPU design; testbenches drive the memory ports directly.

---
 rtl/mips_cpu_harvard_core_if.sv | 21 ++
 rtl/mips_cpu_harvard_core.sv | 156 +++++++++++++++
 tb/tb_mips_cpu_harvard_core.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_harvard_core_if.sv
// Harvard memory bus between the CPU core and its external instruction and data memories.
// Both memories respond combinationally to the addresses the core presents.
interface mips_cpu_harvard_core_if;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic [31:0] data_address;
  logic        data_write;
  logic        data_read;
  logic [31:0] data_writedata;
  logic [31:0] data_readdata;

  modport master (
    output instr_address, data_address, data_write, data_read, data_writedata,
    input  instr_readdata, data_readdata
  );

  modport slave (
    input  instr_address, data_address, data_write, data_read, data_writedata,
    output instr_readdata, data_readdata
  );
endinterface

// File: rtl/mips_cpu_harvard_core.sv
// Single-cycle MIPS-I subset core: PC, 32x32 register file, decode, ALU, one-slot delayed branches.
// Define CLK_ENABLE_EN to gate all state updates and memory strobes with clk_enable.
module mips_cpu_harvard_core #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clk_enable,
  output logic                           active,
  output logic [31:0]                    register_v0,
  mips_cpu_harvard_core_if.master        mem
);

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDIU = 6'h09, OP_SLTI = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E, OP_LUI = 6'h0F,
                         OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADDU = 6'h21,
                         F_SUBU = 6'h23, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26,
                         F_SLT = 6'h2A, F_SLTU = 6'h2B;

  logic [31:0] pc;
  logic [31:0] regs [32];
  logic        br_pend;
  logic [31:0] br_tgt;
  logic        halt_pend;

  logic        adv;
  logic        run;

`ifdef CLK_ENABLE_EN
  assign adv = clk_enable;
`else
  logic unused_clk_enable;
  assign unused_clk_enable = clk_enable;
  assign adv = 1'b1;
`endif
  assign run = active & adv;

  logic [31:0] instr;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] simm, zimm, rs_val, rt_val, pc4, jtgt, btgt, addr;

  assign instr  = mem.instr_readdata;
  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign simm   = {{16{imm[15]}}, imm};
  assign zimm   = {16'd0, imm};
  assign rs_val = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign rt_val = (rt == 5'd0) ? 32'd0 : regs[rt];
  assign pc4    = pc + 32'd4;
  assign jtgt   = {pc4[31:28], instr[25:0], 2'b00};
  assign btgt   = pc4 + {simm[29:0], 2'b00};
  assign addr   = rs_val + simm;

  logic        wen, is_lw, is_sw, take, halt_now;
  logic [4:0]  waddr;
  logic [31:0] wdata, tgt;

  always_comb begin
    wen      = 1'b0;
    waddr    = rd;
    wdata    = 32'd0;
    is_lw    = 1'b0;
    is_sw    = 1'b0;
    take     = 1'b0;
    tgt      = btgt;
    halt_now = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          F_ADDU: begin wen = 1'b1; wdata = rs_val + rt_val; end
          F_SUBU: begin wen = 1'b1; wdata = rs_val - rt_val; end
          F_AND:  begin wen = 1'b1; wdata = rs_val & rt_val; end
          F_OR:   begin wen = 1'b1; wdata = rs_val | rt_val; end
          F_XOR:  begin wen = 1'b1; wdata = rs_val ^ rt_val; end
          F_SLT:  begin wen = 1'b1; wdata = {31'd0, $signed(rs_val) < $signed(rt_val)}; end
          F_SLTU: begin wen = 1'b1; wdata = {31'd0, rs_val < rt_val}; end
          F_SLL:  begin wen = 1'b1; wdata = rt_val << shamt; end
          F_SRL:  begin wen = 1'b1; wdata = rt_val >> shamt; end
          F_JR: begin
            take     = 1'b1;
            tgt      = rs_val;
            halt_now = (rs_val == 32'd0);
          end
          default: ;
        endcase
      end
      OP_J:   begin take = 1'b1; tgt = jtgt; end
      OP_JAL: begin
        take  = 1'b1;
        tgt   = jtgt;
        wen   = 1'b1;
        waddr = 5'd31;
        wdata = pc + 32'd8;
      end
      OP_BEQ:   take = (rs_val == rt_val);
      OP_BNE:   take = (rs_val != rt_val);
      OP_ADDIU: begin wen = 1'b1; waddr = rt; wdata = rs_val + simm; end
      OP_SLTI:  begin wen = 1'b1; waddr = rt; wdata = {31'd0, $signed(rs_val) < $signed(simm)}; end
      OP_SLTIU: begin wen = 1'b1; waddr = rt; wdata = {31'd0, rs_val < simm}; end
      OP_ANDI:  begin wen = 1'b1; waddr = rt; wdata = rs_val & zimm; end
      OP_ORI:   begin wen = 1'b1; waddr = rt; wdata = rs_val | zimm; end
      OP_XORI:  begin wen = 1'b1; waddr = rt; wdata = rs_val ^ zimm; end
      OP_LUI:   begin wen = 1'b1; waddr = rt; wdata = {imm, 16'd0}; end
      OP_LW: begin
        wen   = 1'b1;
        waddr = rt;
        wdata = mem.data_readdata;
        is_lw = 1'b1;
      end
      OP_SW:    is_sw = 1'b1;
      default: ;
    endcase
  end

  // A taken branch is remembered for one instruction so its delay slot runs first.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_VECTOR;
      br_pend   <= 1'b0;
      br_tgt    <= 32'd0;
      halt_pend <= 1'b0;
      active    <= 1'b1;
    end else if (run) begin
      pc        <= br_pend ? br_tgt : pc4;
      br_pend   <= take;
      br_tgt    <= tgt;
      halt_pend <= halt_now;
      if (halt_pend) active <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else if (run && wen && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign register_v0        = regs[2];
  assign mem.instr_address  = pc;
  assign mem.data_address   = (is_lw || is_sw) ? addr : 32'd0;
  assign mem.data_write     = run & is_sw;
  assign mem.data_read      = run & is_lw;
  assign mem.data_writedata = is_sw ? rt_val : 32'd0;

endmodule

// File: tb/tb_mips_cpu_harvard_core.sv
// Scoreboard bench: each issued instruction queues its expected $2 and next PC, checked after the edge.
module tb_mips_cpu_harvard_core;
  logic        clk = 1'b0;
  logic        reset;
  logic        clk_enable;
  logic        active;
  logic [31:0] register_v0;

  mips_cpu_harvard_core_if mem ();

  mips_cpu_harvard_core dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .active      (active),
    .register_v0 (register_v0),
    .mem         (mem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] v0_q[$];
  logic [31:0] pc_q[$];
  logic [31:0] exp_pc;

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [4:0] sh, logic [5:0] fn);
    return {6'd0, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jtype(logic [5:0] op, logic [25:0] t);
    return {op, t};
  endfunction

  task automatic issue(input logic [31:0] ins, input logic [31:0] rdat,
                       input logic [31:0] ev0, input logic [31:0] epc);
    mem.instr_readdata = ins;
    mem.data_readdata  = rdat;
    v0_q.push_back(ev0);
    pc_q.push_back(epc);
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem.instr_readdata = 32'd0;
    mem.data_readdata  = 32'd0;
    advance();
    reset = 1'b0;
    #1;
    checks++; if (mem.instr_address !== 32'hBFC00000) begin failures++;
      $display("FAIL reset_pc got=%h exp=%h", mem.instr_address, 32'hBFC00000); end
    checks++; if (register_v0 !== 32'd0) begin failures++;
      $display("FAIL reset_v0 got=%h exp=%h", register_v0, 32'd0); end
    checks++; if (active !== 1'b1) begin failures++;
      $display("FAIL reset_active got=%b exp=1", active); end
    checks++; if ((mem.data_write !== 1'b0) || (mem.data_read !== 1'b0)) begin failures++;
      $display("FAIL reset_strobes got=%b%b exp=00", mem.data_write, mem.data_read); end
    exp_pc = 32'hBFC00000;
  endtask

  task automatic test_load_store();
    logic [31:0] ins[3], rdat[3], ev0[3], eaddr[3], ewd[3];
    logic        ewr[3], erd[3];
    logic [31:0] e;
    ins[0] = 32'h2402A000; rdat[0] = 32'd0;        ev0[0] = 32'hFFFFA000;
    eaddr[0] = 32'd0;      ewd[0] = 32'd0;         ewr[0] = 1'b0; erd[0] = 1'b0;
    ins[1] = 32'hAC420A00; rdat[1] = 32'd0;        ev0[1] = 32'hFFFFA000;
    eaddr[1] = 32'hFFFFAA00; ewd[1] = 32'hFFFFA000; ewr[1] = 1'b1; erd[1] = 1'b0;
    ins[2] = 32'h8C420A00; rdat[2] = 32'hCC000000; ev0[2] = 32'hCC000000;
    eaddr[2] = 32'hFFFFAA00; ewd[2] = 32'd0;       ewr[2] = 1'b0; erd[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(ins[i], rdat[i], ev0[i], exp_pc + 32'd4);
      checks++; if (mem.data_address !== eaddr[i]) begin failures++;
        $display("FAIL ls_addr[%0d] got=%h exp=%h", i, mem.data_address, eaddr[i]); end
      checks++; if (mem.data_writedata !== ewd[i]) begin failures++;
        $display("FAIL ls_wdata[%0d] got=%h exp=%h", i, mem.data_writedata, ewd[i]); end
      checks++; if ((mem.data_write !== ewr[i]) || (mem.data_read !== erd[i])) begin failures++;
        $display("FAIL ls_strobe[%0d] got=%b%b exp=%b%b", i, mem.data_write, mem.data_read, ewr[i], erd[i]); end
      advance();
      e = v0_q.pop_front();
      checks++; if (register_v0 !== e) begin failures++;
        $display("FAIL ls_v0[%0d] got=%h exp=%h", i, register_v0, e); end
      e = pc_q.pop_front();
      checks++; if (mem.instr_address !== e) begin failures++;
        $display("FAIL ls_pc[%0d] got=%h exp=%h", i, mem.instr_address, e); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_alu();
    logic [31:0] ins[19], ev0[19];
    logic [31:0] e;
    ins[0]  = itype(6'h09, 5'd0, 5'd3, 16'hFFFD);      ev0[0]  = 32'hCC000000;
    ins[1]  = itype(6'h0D, 5'd0, 5'd4, 16'h8005);      ev0[1]  = 32'hCC000000;
    ins[2]  = rtype(5'd3, 5'd4, 5'd2, 5'd0, 6'h21);    ev0[2]  = 32'h00008002;
    ins[3]  = rtype(5'd3, 5'd4, 5'd2, 5'd0, 6'h23);    ev0[3]  = 32'hFFFF7FF8;
    ins[4]  = rtype(5'd3, 5'd4, 5'd2, 5'd0, 6'h24);    ev0[4]  = 32'h00008005;
    ins[5]  = rtype(5'd3, 5'd4, 5'd2, 5'd0, 6'h25);    ev0[5]  = 32'hFFFFFFFD;
    ins[6]  = rtype(5'd3, 5'd4, 5'd2, 5'd0, 6'h26);    ev0[6]  = 32'hFFFF7FF8;
    ins[7]  = rtype(5'd3, 5'd4, 5'd2, 5'd0, 6'h2A);    ev0[7]  = 32'd1;
    ins[8]  = rtype(5'd3, 5'd4, 5'd2, 5'd0, 6'h2B);    ev0[8]  = 32'd0;
    ins[9]  = rtype(5'd0, 5'd4, 5'd2, 5'd4, 6'h00);    ev0[9]  = 32'h00080050;
    ins[10] = rtype(5'd0, 5'd3, 5'd2, 5'd28, 6'h02);   ev0[10] = 32'h0000000F;
    ins[11] = itype(6'h0F, 5'd0, 5'd2, 16'h1234);      ev0[11] = 32'h12340000;
    ins[12] = itype(6'h0C, 5'd3, 5'd2, 16'hFFFF);      ev0[12] = 32'h0000FFFD;
    ins[13] = itype(6'h0E, 5'd3, 5'd2, 16'h00FF);      ev0[13] = 32'hFFFFFF02;
    ins[14] = itype(6'h0A, 5'd3, 5'd2, 16'h0001);      ev0[14] = 32'd1;
    ins[15] = itype(6'h0B, 5'd3, 5'd2, 16'h0001);      ev0[15] = 32'd0;
    ins[16] = itype(6'h0B, 5'd4, 5'd2, 16'hFFFF);      ev0[16] = 32'd1;
    ins[17] = rtype(5'd3, 5'd4, 5'd0, 5'd0, 6'h21);    ev0[17] = 32'd1;
    ins[18] = rtype(5'd0, 5'd0, 5'd2, 5'd0, 6'h21);    ev0[18] = 32'd0;
    for (int i = 0; i < 19; i++) begin
      issue(ins[i], 32'hDEADBEEF, ev0[i], exp_pc + 32'd4);
      advance();
      e = v0_q.pop_front();
      checks++; if (register_v0 !== e) begin failures++;
        $display("FAIL alu_v0[%0d] got=%h exp=%h", i, register_v0, e); end
      e = pc_q.pop_front();
      checks++; if (mem.instr_address !== e) begin failures++;
        $display("FAIL alu_pc[%0d] got=%h exp=%h", i, mem.instr_address, e); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins[10], ev0[10], epc[10];
    logic [31:0] p, t, j2, tmp, e;
    p   = exp_pc;
    tmp = p + 32'd24;
    t   = {tmp[31:28], 26'h0000100, 2'b00};
    tmp = t + 32'd4;
    j2  = {tmp[31:28], 26'h0000040, 2'b00};
    ins[0] = itype(6'h04, 5'd0, 5'd0, 16'd2);   ev0[0] = 32'd0;        epc[0] = p + 32'd4;
    ins[1] = itype(6'h09, 5'd0, 5'd2, 16'd5);   ev0[1] = 32'd5;        epc[1] = p + 32'd12;
    ins[2] = itype(6'h05, 5'd0, 5'd0, 16'd5);   ev0[2] = 32'd5;        epc[2] = p + 32'd16;
    ins[3] = itype(6'h09, 5'd0, 5'd2, 16'd6);   ev0[3] = 32'd6;        epc[3] = p + 32'd20;
    ins[4] = jtype(6'h02, 26'h0000100);         ev0[4] = 32'd6;        epc[4] = p + 32'd24;
    ins[5] = itype(6'h09, 5'd2, 5'd2, 16'd1);   ev0[5] = 32'd7;        epc[5] = t;
    ins[6] = jtype(6'h03, 26'h0000040);         ev0[6] = 32'd7;        epc[6] = t + 32'd4;
    ins[7] = rtype(5'd31, 5'd0, 5'd2, 5'd0, 6'h21); ev0[7] = t + 32'd8; epc[7] = j2;
    ins[8] = itype(6'h05, 5'd2, 5'd0, 16'hFFFF); ev0[8] = t + 32'd8;   epc[8] = j2 + 32'd4;
    ins[9] = 32'd0;                              ev0[9] = t + 32'd8;   epc[9] = j2;
    for (int i = 0; i < 10; i++) begin
      issue(ins[i], 32'd0, ev0[i], epc[i]);
      advance();
      e = v0_q.pop_front();
      checks++; if (register_v0 !== e) begin failures++;
        $display("FAIL br_v0[%0d] got=%h exp=%h", i, register_v0, e); end
      e = pc_q.pop_front();
      checks++; if (mem.instr_address !== e) begin failures++;
        $display("FAIL br_pc[%0d] got=%h exp=%h", i, mem.instr_address, e); end
    end
  endtask

  task automatic test_reset_mid_branch();
    issue(itype(6'h04, 5'd0, 5'd0, 16'd10), 32'd0, 32'd0, 32'd0);
    advance();
    reset = 1'b1;
    mem.instr_readdata = 32'd0;
    advance();
    reset = 1'b0;
    v0_q.delete();
    pc_q.delete();
    checks++; if (mem.instr_address !== 32'hBFC00000) begin failures++;
      $display("FAIL midrst_pc got=%h exp=%h", mem.instr_address, 32'hBFC00000); end
    checks++; if (register_v0 !== 32'd0) begin failures++;
      $display("FAIL midrst_v0 got=%h exp=%h", register_v0, 32'd0); end
    issue(32'd0, 32'd0, 32'd0, 32'hBFC00004);
    advance();
    begin
      logic [31:0] e;
      e = pc_q.pop_front();
      checks++; if (mem.instr_address !== e) begin failures++;
        $display("FAIL midrst_discard got=%h exp=%h", mem.instr_address, e); end
      e = v0_q.pop_front();
      checks++; if (register_v0 !== e) begin failures++;
        $display("FAIL midrst_v0b got=%h exp=%h", register_v0, e); end
    end
  endtask

  task automatic test_halt();
    logic [31:0] ins[5], ev0[5], epc[5];
    logic        eact[5];
    logic [31:0] e;
    ins[0] = rtype(5'd0, 5'd0, 5'd0, 5'd0, 6'h08); ev0[0] = 32'd0; epc[0] = 32'hBFC00008; eact[0] = 1'b1;
    ins[1] = itype(6'h09, 5'd0, 5'd2, 16'd7);      ev0[1] = 32'd7; epc[1] = 32'd0;        eact[1] = 1'b0;
    ins[2] = itype(6'h2B, 5'd0, 5'd2, 16'd0);      ev0[2] = 32'd7; epc[2] = 32'd0;        eact[2] = 1'b0;
    ins[3] = itype(6'h09, 5'd0, 5'd2, 16'd9);      ev0[3] = 32'd7; epc[3] = 32'd0;        eact[3] = 1'b0;
    ins[4] = itype(6'h23, 5'd0, 5'd2, 16'd4);      ev0[4] = 32'd7; epc[4] = 32'd0;        eact[4] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue(ins[i], 32'h55AA55AA, ev0[i], epc[i]);
      if (i >= 2) begin
        checks++; if ((mem.data_write !== 1'b0) || (mem.data_read !== 1'b0)) begin failures++;
          $display("FAIL halt_strobe[%0d] got=%b%b exp=00", i, mem.data_write, mem.data_read); end
      end
      advance();
      e = v0_q.pop_front();
      checks++; if (register_v0 !== e) begin failures++;
        $display("FAIL halt_v0[%0d] got=%h exp=%h", i, register_v0, e); end
      e = pc_q.pop_front();
      checks++; if (mem.instr_address !== e) begin failures++;
        $display("FAIL halt_pc[%0d] got=%h exp=%h", i, mem.instr_address, e); end
      checks++; if (active !== eact[i]) begin failures++;
        $display("FAIL halt_active[%0d] got=%b exp=%b", i, active, eact[i]); end
    end
  endtask

  initial begin
    reset = 1'b1;
    clk_enable = 1'b1;
    mem.instr_readdata = 32'd0;
    mem.data_readdata  = 32'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_store();
    test_alu();
    test_branch();
    test_reset_mid_branch();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
